uart_tx_arb: RTL and testbench

- Arbitrates the single UART transmitter between two byte producers: requester A (CPU MMIO store path) and requester B (debug/loader echo path).
- Sequences the tx core's start/busy handshake.
- Sits between the producers and the 115200 bps UART tx core inside top; the tx core output drives pin tx.

---
 rtl/uart_tx_arb.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arb: round-robin arbiter of two byte producers onto a single |
// | UART tx core. Define UART_ARB_LOCK_EN for per-packet grant locking.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_arb #(
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned LOCK_MAX      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rr_q, rr_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             a_ready_q, a_ready_d;
  logic             b_ready_q, b_ready_d;
  logic [1:0]       grant_q, grant_d;
  logic             err_q, err_d;

  logic a_elig, b_elig, pick_b, take, accept;

`ifdef UART_ARB_LOCK_EN
  localparam int unsigned LCNT_W = $clog2(LOCK_MAX + 1);

  logic              lock_q, lock_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic              win_last;

  // While locked only the current owner (grant_q) may be selected.
  assign a_elig   = a_valid & (~lock_q | ~grant_q[1]);
  assign b_elig   = b_valid & (~lock_q |  grant_q[1]);
  assign lcnt_inc = lcnt_q + LCNT_W'(1);
  assign win_last = pick_b ? b_last : a_last;
`else
  logic unused_last;

  assign a_elig      = a_valid;
  assign b_elig      = b_valid;
  assign unused_last = a_last ^ b_last ^ LOCK_MAX[0];
`endif

  // rr_q=0 favours A, rr_q=1 favours B
  assign pick_b  = b_elig & (~a_elig | rr_q);
  assign take    = (a_elig | b_elig) & ~tx_busy;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    a_ready_d  = 1'b0;
    b_ready_d  = 1'b0;
    grant_d    = grant_q;
    err_d      = 1'b0;
    accept     = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
    lcnt_d     = lcnt_q;
`endif

    case (state_q)
      IDLE: accept = take;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(START_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
          lcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        // The cycle busy falls already counts as idle, so a waiting byte
        // starts one cycle after the core finishes.
        if (!tx_busy) begin
          state_d = IDLE;
          accept  = take;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tx_start_d = 1'b1;
      tx_data_d  = pick_b ? b_data : a_data;
      a_ready_d  = ~pick_b;
      b_ready_d  = pick_b;
      grant_d    = pick_b ? 2'b10 : 2'b01;
      rr_d       = ~pick_b;
      state_d    = WAIT_BUSY;
      cnt_d      = '0;
`ifdef UART_ARB_LOCK_EN
      if (win_last || (lcnt_inc == LCNT_W'(LOCK_MAX))) begin
        lock_d = 1'b0;
        lcnt_d = '0;
      end else begin
        lock_d = 1'b1;
        lcnt_d = lcnt_inc;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      a_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      a_ready_q  <= a_ready_d;
      b_ready_q  <= b_ready_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
      lcnt_q     <= lcnt_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign a_ready  = a_ready_q;
  assign b_ready  = b_ready_q;
  assign grant    = grant_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arb: vector table, directed corner cases and randomized   |
// | traffic against a transaction-level model of uart_tx_arb.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, a_last = 1'b1, b_valid = 1'b0, b_last = 1'b1;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ready, b_ready, tx_start, err;
  logic [7:0] tx_data;
  logic [1:0] grant;

  logic tx_busy = 1'b0;
  int   tx_rem  = 0;
  logic tx_drop = 1'b0;
  int   tx_len  = 1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  uart_tx_arb #(.START_TIMEOUT(4), .LOCK_MAX(64)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  // tx core: busy rises the cycle after a start and stays high tx_len cycles;
  // with tx_drop set it ignores the start entirely.
  always @(posedge clk) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      tx_rem  <= 0;
    end else if (tx_start && !tx_drop) begin
      tx_busy <= 1'b1;
      tx_rem  <= tx_len;
    end else if (tx_rem > 1) begin
      tx_rem <= tx_rem - 1;
    end else begin
      tx_rem  <= 0;
      tx_busy <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b1; b_last = 1'b1;
    tx_drop = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic       r;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       st;
    logic [7:0] td;
    logic       ar;
    logic       br;
    logic [1:0] gr;
    logic       er;
  } vec_t;

  vec_t tbl[19];

  logic [7:0] qa[$], qb[$];
  logic [7:0] seq[8];
  logic [7:0] exp_seq[$];
  int  sc[2];
  logic [7:0] sd[2];

  initial begin : main
    int  nst, nrdy, nerr, wide, fall, ec, exp_err;
    bit  prev_start, prev_rdy, prev_busy, pa, pb, rr_m, win_b, seen;
    logic [7:0] exp_d;

    // reset behaviour, then 4-byte A/B contention with a 1-cycle-busy core
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = '{1'b0, 1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 8'h41, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 8'h41, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[10] = tbl[9];
    tbl[11] = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 8'h42, 1'b0, 1'b1, 2'b10, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 8'h42, 1'b0, 1'b0, 2'b10, 1'b0};
    tbl[13] = tbl[12];
    tbl[14] = tbl[8];
    tbl[15] = tbl[9];
    tbl[16] = tbl[9];
    tbl[17] = tbl[11];
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h42, 1'b0, 1'b0, 2'b10, 1'b0};

    tx_len = 1;
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].r; a_valid = tbl[i].av; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_data = tbl[i].bd;
      step();
      chk($sformatf("vec%0d {start,data,ardy,brdy,grant,err}", i),
          {18'd0, tx_start, tx_data, a_ready, b_ready, grant, err},
          {18'd0, tbl[i].st, tbl[i].td, tbl[i].ar, tbl[i].br, tbl[i].gr, tbl[i].er});
    end

    // single requester, long busy: 0x55 then 0xAA
    do_reset();
    tx_len = 20;
    a_valid = 1'b1; a_data = 8'h55;
    nst = 0; nrdy = 0; wide = 0; fall = -100;
    prev_start = 0; prev_rdy = 0; prev_busy = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_start && prev_start) wide++;
      if (a_ready && prev_rdy) wide++;
      if (prev_busy && !tx_busy && nst == 1) fall = cyc;
      if (tx_start) begin
        if (nst < 2) begin sd[nst] = tx_data; sc[nst] = cyc; end
        nst++;
      end
      if (a_ready) begin
        nrdy++;
        if (a_data == 8'h55) a_data = 8'hAA; else a_valid = 1'b0;
      end
      prev_start = tx_start; prev_rdy = a_ready; prev_busy = tx_busy;
    end
    chk("single_starts", nst, 2);
    chk("single_readys", nrdy, 2);
    chk("single_pulse_width_violations", wide, 0);
    chk("single_byte0", sd[0], 8'h55);
    chk("single_byte1", sd[1], 8'hAA);
    chk("single_restart_after_busy_fall", sc[1] - fall, 1);

    // start timeout: core never raises busy
    do_reset();
    tx_drop = 1'b1;
    a_valid = 1'b1; a_data = 8'h33;
    nst = 0; nrdy = 0; nerr = 0; ec = -100;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx_start) begin
        if (nst < 2) begin sd[nst] = tx_data; sc[nst] = cyc; end
        nst++;
      end
      if (err) begin
        if (nerr == 0) ec = cyc;
        nerr++;
      end
      if (a_ready) begin
        nrdy++;
        if (a_data == 8'h33) a_data = 8'h34; else a_valid = 1'b0;
      end
    end
    chk("timeout_starts", nst, 2);
    chk("timeout_err_delay", ec - sc[0], 4);
    chk("timeout_err_pulses", nerr, 2);
    chk("timeout_readys", nrdy, 2);
    chk("timeout_next_byte", sd[1], 8'h34);
    chk("timeout_next_after_err", (sc[1] > ec) ? 1 : 0, 1);

    // packet lock ordering
    do_reset();
    tx_len = 1;
    a_valid = 1'b1; a_data = 8'h01; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h7E; b_last = 1'b1;
    nst = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_start && nst < 8) begin seq[nst] = tx_data; nst++; end
      if (a_ready) begin
        if (a_data == 8'h01) a_data = 8'h02;
        else if (a_data == 8'h02) begin a_data = 8'h03; a_last = 1'b1; end
        else a_valid = 1'b0;
      end
    end
`ifdef UART_ARB_LOCK_EN
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h7E};
`else
    exp_seq = '{8'h01, 8'h7E, 8'h02, 8'h7E, 8'h03};
`endif
    chk("lock_enough_starts", (nst >= exp_seq.size()) ? 1 : 0, 1);
    for (int k = 0; k < exp_seq.size(); k++)
      chk($sformatf("lock_seq%0d", k), seq[k], exp_seq[k]);

    // reset during WAIT_DONE
    do_reset();
    tx_len = 20;
    a_valid = 1'b1; a_data = 8'h66;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (a_ready) a_valid = 1'b0;
      if (tx_busy) seen = 1;
    end
    chk("midrst_busy_seen", seen, 1);
    step();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 8'h61; b_valid = 1'b1; b_data = 8'h62;
    step();
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_no_start", tx_start, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_first_after {start,data,ardy,brdy,grant}",
        {tx_start, tx_data, a_ready, b_ready, grant}, {1'b1, 8'h61, 1'b1, 1'b0, 2'b01});

    // randomized traffic vs transaction-level model
    do_reset();
    tx_len = 3;
    qa.delete(); qb.delete();
    for (int i = 0; i < 25; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
    end
    pa = 0; pb = 0; rr_m = 0; exp_err = -1;
    for (int i = 0; i < 3000 && ((qa.size() + qb.size()) > 0 || exp_err >= cyc); i++) begin
      if (!pa && qa.size() > 0 && $urandom_range(0, 1) == 1) pa = 1;
      if (!pb && qb.size() > 0 && $urandom_range(0, 1) == 1) pb = 1;
      a_valid = pa; a_data = pa ? qa[0] : 8'h00;
      b_valid = pb; b_data = pb ? qb[0] : 8'h00;
      step();
      if (tx_start) begin
        chk("rnd_start_has_valid", (pa || pb) ? 1 : 0, 1);
        if (pa || pb) begin
          win_b = (pa && pb) ? rr_m : pb;
          exp_d = win_b ? qb[0] : qa[0];
          chk("rnd_xfer {data,ardy,brdy,grant}",
              {tx_data, a_ready, b_ready, grant},
              {exp_d, !win_b, win_b, win_b ? 2'b10 : 2'b01});
          if (win_b) begin void'(qb.pop_front()); pb = 0; end
          else begin void'(qa.pop_front()); pa = 0; end
          rr_m = !win_b;
          tx_drop = ($urandom_range(0, 4) == 0);
          tx_len  = $urandom_range(1, 6);
          if (tx_drop) exp_err = cyc + 4;
        end
      end else begin
        chk("rnd_no_ready_without_start", {a_ready, b_ready}, 2'b00);
      end
      chk("rnd_err", err, (cyc == exp_err) ? 1 : 0);
    end
    chk("rnd_drained", qa.size() + qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
